// File: rtl/spread_pkg.sv
// Shared types and defaults for the spread scheduler: FSM state encoding,
// the tagged quote record and the default refresh/timeout constants.
package spread_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int DEFAULT_REFRESH_PERIOD = 1024;
  localparam int DEFAULT_RESP_TIMEOUT   = 16;

  // The quote record is sized for the widest supported configuration;
  // the scheduler zero-extends into it and slices back out.
  localparam int QUOTE_SYM_MAX_W  = 8;
  localparam int QUOTE_DATA_MAX_W = 64;

  typedef struct packed {
    logic [QUOTE_SYM_MAX_W-1:0]  symbol;
    logic [QUOTE_DATA_MAX_W-1:0] spread;
  } quote_t;

endpackage

// File: rtl/spread_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index
// strictly after the last grant, wrapping. The pointer lives in the caller.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic         en,
  output logic [W-1:0] gnt,
  output logic         gnt_valid
);

  logic [W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last) + i) % N);
      if (en && req[idx]) begin
        gnt       = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spread_scheduler.sv
// Time-shares one spread datapath between NUM_SYMBOLS channels with a periodic
// forced refresh. Optional SPREAD_SCHED_STATS_EN adds issue/timeout counters.
module spread_scheduler
  import spread_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SYMBOLS    = 4,
  parameter int SYM_W          = $clog2(NUM_SYMBOLS),
  parameter int REFRESH_PERIOD = DEFAULT_REFRESH_PERIOD,
  parameter int RESP_TIMEOUT   = DEFAULT_RESP_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_vol_valid,
  input  logic [SYM_W-1:0]      i_vol_symbol,
  input  logic [DATA_WIDTH-1:0] i_volatility,
  input  logic [DATA_WIDTH-1:0] i_curr_time,
  output logic                  o_req_valid,
  output logic [DATA_WIDTH-1:0] o_req_volatility,
  output logic [DATA_WIDTH-1:0] o_req_time,
  input  logic                  i_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_resp_spread,
  output logic                  o_quote_valid,
  output logic [SYM_W-1:0]      o_quote_symbol,
  output logic [DATA_WIDTH-1:0] o_quote_spread,
  output logic                  o_busy,
  output logic                  o_err_timeout
`ifdef SPREAD_SCHED_STATS_EN
  ,
  output logic [15:0]           o_stat_issued,
  output logic [15:0]           o_stat_timeouts
`endif
);

  localparam int REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  sched_state_e           state_q, state_d;
  logic [NUM_SYMBOLS-1:0] pending_q, pending_d, seen_q;
  logic [DATA_WIDTH-1:0]  vol_q [NUM_SYMBOLS];
  logic [REF_W-1:0]       ref_cnt_q;
  logic [TMO_W-1:0]       tmo_cnt_q;
  logic [SYM_W-1:0]       last_q, gnt_q, arb_gnt;
  logic                   arb_valid, grant;
  logic                   refresh_wrap, resp_hit, tmo_hit;
  logic                   req_valid_d, quote_valid_d, err_d;
  quote_t                 quote_q;
  logic                   unused_quote;

  rr_arbiter #(.N(NUM_SYMBOLS), .W(SYM_W)) u_arb (
    .req       (pending_q & seen_q),
    .last      (last_q),
    .en        (state_q == IDLE),
    .gnt       (arb_gnt),
    .gnt_valid (arb_valid)
  );

  assign grant        = (state_q == IDLE) && arb_valid;
  assign refresh_wrap = (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1));
  // A response on the final WAIT cycle wins over the timeout.
  assign resp_hit     = (state_q == WAIT) && i_resp_valid;
  assign tmo_hit      = (state_q == WAIT) && !i_resp_valid &&
                        (tmo_cnt_q == TMO_W'(RESP_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (resp_hit || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_valid_d   = (state_q == ISSUE);
    quote_valid_d = resp_hit;
    err_d         = tmo_hit;
    o_busy        = (state_q != IDLE);
  end

  // Sets are applied after the grant clear so a same-cycle update re-arms it.
  always_comb begin
    pending_d = pending_q;
    if (grant) pending_d[arb_gnt] = 1'b0;
    if (tmo_hit) pending_d[gnt_q] = 1'b1;
    if (refresh_wrap) pending_d = pending_d | seen_q;
    if (i_vol_valid) pending_d[i_vol_symbol] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= IDLE;
      pending_q        <= '0;
      seen_q           <= '0;
      ref_cnt_q        <= '0;
      tmo_cnt_q        <= '0;
      last_q           <= '0;
      gnt_q            <= '0;
      o_req_valid      <= 1'b0;
      o_req_volatility <= '0;
      o_req_time       <= '0;
      o_quote_valid    <= 1'b0;
      o_err_timeout    <= 1'b0;
      quote_q          <= '0;
      for (int i = 0; i < NUM_SYMBOLS; i++) vol_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      ref_cnt_q     <= refresh_wrap ? '0 : ref_cnt_q + 1'b1;
      o_req_valid   <= req_valid_d;
      o_quote_valid <= quote_valid_d;
      o_err_timeout <= err_d;
      if (i_vol_valid) begin
        vol_q[i_vol_symbol]  <= i_volatility;
        seen_q[i_vol_symbol] <= 1'b1;
      end
      if (grant) begin
        gnt_q            <= arb_gnt;
        last_q           <= arb_gnt;
        o_req_volatility <= vol_q[arb_gnt];
        o_req_time       <= i_curr_time;
      end
      if (state_q == ISSUE) tmo_cnt_q <= '0;
      else if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (resp_hit) begin
        quote_q.symbol <= QUOTE_SYM_MAX_W'(gnt_q);
        quote_q.spread <= QUOTE_DATA_MAX_W'(i_resp_spread);
      end
    end
  end

  assign o_quote_symbol = quote_q.symbol[SYM_W-1:0];
  assign o_quote_spread = quote_q.spread[DATA_WIDTH-1:0];
  assign unused_quote   = ^quote_q;

`ifdef SPREAD_SCHED_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stat_issued   <= '0;
      o_stat_timeouts <= '0;
    end else begin
      if (o_req_valid && (o_stat_issued != 16'hFFFF))
        o_stat_issued <= o_stat_issued + 16'd1;
      if (o_err_timeout && (o_stat_timeouts != 16'hFFFF))
        o_stat_timeouts <= o_stat_timeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spread_scheduler.sv
// Directed bench for spread_scheduler: a vector table for the basic issue/quote
// path plus hand sequences for arbitration order, timeout, refresh and reset.
module tb_spread_scheduler;

  localparam int DW = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] curr_time = '0;
  always @(negedge clk) curr_time = curr_time + 1;

  int errors = 0;
  int checks = 0;

  // Main DUT (default refresh period, far beyond any single scenario).
  logic          reset, vol_valid, resp_valid;
  logic [SW-1:0] vol_symbol;
  logic [DW-1:0] volatility, resp_spread;
  logic          req_valid, quote_valid, busy, err_timeout;
  logic [DW-1:0] req_vol, req_time, quote_spread;
  logic [SW-1:0] quote_symbol;
`ifdef SPREAD_SCHED_STATS_EN
  logic [15:0]   stat_issued, stat_timeouts;
`endif

  spread_scheduler u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_vol_valid(vol_valid), .i_vol_symbol(vol_symbol), .i_volatility(volatility),
    .i_curr_time(curr_time),
    .o_req_valid(req_valid), .o_req_volatility(req_vol), .o_req_time(req_time),
    .i_resp_valid(resp_valid), .i_resp_spread(resp_spread),
    .o_quote_valid(quote_valid), .o_quote_symbol(quote_symbol), .o_quote_spread(quote_spread),
    .o_busy(busy), .o_err_timeout(err_timeout)
`ifdef SPREAD_SCHED_STATS_EN
    , .o_stat_issued(stat_issued), .o_stat_timeouts(stat_timeouts)
`endif
  );

  // Second DUT with a short refresh period for the wrap scenario.
  logic          b_reset, b_vol_valid, b_resp_valid;
  logic [SW-1:0] b_vol_symbol;
  logic [DW-1:0] b_volatility, b_resp_spread;
  logic          b_req_valid, b_quote_valid, b_busy, b_err;
  logic [DW-1:0] b_req_vol, b_req_time, b_quote_spread;
  logic [SW-1:0] b_quote_symbol;
  logic          unused_b;
`ifdef SPREAD_SCHED_STATS_EN
  logic [15:0]   b_stat_issued, b_stat_timeouts;
`endif

  spread_scheduler #(.REFRESH_PERIOD(8)) u_dut_ref (
    .i_clk(clk), .i_reset(b_reset),
    .i_vol_valid(b_vol_valid), .i_vol_symbol(b_vol_symbol), .i_volatility(b_volatility),
    .i_curr_time(curr_time),
    .o_req_valid(b_req_valid), .o_req_volatility(b_req_vol), .o_req_time(b_req_time),
    .i_resp_valid(b_resp_valid), .i_resp_spread(b_resp_spread),
    .o_quote_valid(b_quote_valid), .o_quote_symbol(b_quote_symbol), .o_quote_spread(b_quote_spread),
    .o_busy(b_busy), .o_err_timeout(b_err)
`ifdef SPREAD_SCHED_STATS_EN
    , .o_stat_issued(b_stat_issued), .o_stat_timeouts(b_stat_timeouts)
`endif
  );

`ifdef SPREAD_SCHED_STATS_EN
  assign unused_b = ^{b_req_time, b_quote_spread, b_stat_issued, b_stat_timeouts};
`else
  assign unused_b = ^{b_req_time, b_quote_spread};
`endif

  // Scoreboard: expected request volatilities and expected quote tags.
  logic [DW-1:0] exp_q[$];
  logic [SW-1:0] exp_sym_q[$];
  logic [SW-1:0] exp_qsym_q[$];
  logic [DW-1:0] exp_qspr_q[$];

  typedef struct {
    logic          vv;
    logic [SW-1:0] vs;
    logic [DW-1:0] vol;
    logic          rv;
    logic [DW-1:0] rs;
    logic          e_req;
    logic [DW-1:0] e_vol;
    logic          e_q;
    logic [SW-1:0] e_sym;
    logic [DW-1:0] e_spr;
    logic          e_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vol_valid = 1'b0; vol_symbol = '0; volatility = '0;
    resp_valid = 1'b0; resp_spread = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
    check({tag, "_req_vol"}, 64'(req_vol), 64'd0);
    check({tag, "_req_time"}, 64'(req_time), 64'd0);
    check({tag, "_quote_valid"}, 64'(quote_valid), 64'd0);
    check({tag, "_quote_sym"}, 64'(quote_symbol), 64'd0);
    check({tag, "_quote_spr"}, 64'(quote_spread), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err_timeout), 64'd0);
`ifdef SPREAD_SCHED_STATS_EN
    check({tag, "_stat_issued"}, 64'(stat_issued), 64'd0);
    check({tag, "_stat_timeouts"}, 64'(stat_timeouts), 64'd0);
`endif
  endtask

  // Acts as a zero-latency spread unit (spread = vol + 0x1000) and scores traffic.
  task automatic run_traffic(input string tag, input int ncycles);
    logic          outstanding;
    logic [DW-1:0] ev;
    outstanding = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      resp_valid = 1'b0;
      if (quote_valid) begin
        outstanding = 1'b0;
        if (exp_qsym_q.size() == 0) begin
          check({tag, "_unexpected_quote"}, 64'd1, 64'd0);
        end else begin
          check({tag, "_quote_sym"}, 64'(quote_symbol), 64'(exp_qsym_q.pop_front()));
          check({tag, "_quote_spr"}, 64'(quote_spread), 64'(exp_qspr_q.pop_front()));
        end
      end
      if (req_valid) begin
        check({tag, "_one_outstanding"}, 64'(outstanding), 64'd0);
        outstanding = 1'b1;
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_req"}, 64'd1, 64'd0);
        end else begin
          ev = exp_q.pop_front();
          check({tag, "_req_vol"}, 64'(req_vol), 64'(ev));
          exp_qsym_q.push_back(exp_sym_q.pop_front());
          exp_qspr_q.push_back(ev + 32'h1000);
        end
        resp_valid  = 1'b1;
        resp_spread = req_vol + 32'h1000;
      end
    end
    resp_valid = 1'b0;
    check({tag, "_reqs_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_quotes_drained"}, 64'(exp_qsym_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] grant_time;
    logic          early;
    logic [DW-1:0] win_q[$];
    logic [SW-1:0] bq_sym_q[$];
    int            pre_win, other, bquotes;
    logic          b_err_seen;

    b_reset = 1'b1; b_vol_valid = 1'b0; b_vol_symbol = '0; b_volatility = '0;
    b_resp_valid = 1'b0; b_resp_spread = '0;
    grant_time = '0;

    // Reset state.
    do_reset();
    check_all_zero("reset");

    // Basic path: update sym2, request two cycles later, quote a cycle after response.
    vecs[0] = '{1'b1, 2'd2, 32'h64, 1'b0, 32'h0,    1'b0, 32'h0,  1'b0, 2'd0, 32'h0,    1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h64, 1'b0, 2'd0, 32'h0,    1'b1};
    vecs[2] = '{1'b0, 2'd0, 32'h0,  1'b0, 32'h0,    1'b1, 32'h64, 1'b0, 2'd0, 32'h0,    1'b1};
    vecs[3] = '{1'b0, 2'd0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h64, 1'b0, 2'd0, 32'h0,    1'b1};
    vecs[4] = '{1'b0, 2'd0, 32'h0,  1'b1, 32'h1234, 1'b0, 32'h64, 1'b1, 2'd2, 32'h1234, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h64, 1'b0, 2'd2, 32'h1234, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 32'h0,  1'b1, 32'h9999, 1'b0, 32'h64, 1'b0, 2'd2, 32'h1234, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 32'h0,  1'b0, 32'h0,    1'b0, 32'h64, 1'b0, 2'd2, 32'h1234, 1'b0};
    for (int i = 0; i < 8; i++) begin
      vol_valid   = vecs[i].vv;
      vol_symbol  = vecs[i].vs;
      volatility  = vecs[i].vol;
      resp_valid  = vecs[i].rv;
      resp_spread = vecs[i].rs;
      if (i == 1) grant_time = curr_time + 1;
      step();
      check($sformatf("vec%0d_req_valid", i), 64'(req_valid), 64'(vecs[i].e_req));
      check($sformatf("vec%0d_req_vol", i), 64'(req_vol), 64'(vecs[i].e_vol));
      check($sformatf("vec%0d_quote_valid", i), 64'(quote_valid), 64'(vecs[i].e_q));
      check($sformatf("vec%0d_quote_sym", i), 64'(quote_symbol), 64'(vecs[i].e_sym));
      check($sformatf("vec%0d_quote_spr", i), 64'(quote_spread), 64'(vecs[i].e_spr));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      check($sformatf("vec%0d_err", i), 64'(err_timeout), 64'd0);
    end
    vol_valid = 1'b0; resp_valid = 1'b0;
    check("vec_req_time", 64'(req_time), 64'(grant_time));
`ifdef SPREAD_SCHED_STATS_EN
    check("vec_stat_issued", 64'(stat_issued), 64'd1);
`endif

    // Round-robin: sym1 wins alone, then 0 and 3 pending -> order 3 before 0.
    do_reset();
    exp_q.push_back(32'h101); exp_sym_q.push_back(2'd1);
    exp_q.push_back(32'h103); exp_sym_q.push_back(2'd3);
    exp_q.push_back(32'h100); exp_sym_q.push_back(2'd0);
    vol_valid = 1'b1;
    vol_symbol = 2'd1; volatility = 32'h101; step();
    vol_symbol = 2'd0; volatility = 32'h100; step();
    vol_symbol = 2'd3; volatility = 32'h103; step();
    vol_valid = 1'b0;
    run_traffic("rr", 30);

    // Timeout: no response for 16 WAIT cycles, then re-issue and answer.
    do_reset();
    vol_valid = 1'b1; vol_symbol = 2'd3; volatility = 32'h33;
    step();
    vol_valid = 1'b0;
    step(); step();
    check("tmo_first_req", 64'(req_valid), 64'd1);
    early = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (err_timeout) early = 1'b1;
      step();
    end
    check("tmo_no_early", 64'(early), 64'd0);
    check("tmo_pulse", 64'(err_timeout), 64'd1);
    check("tmo_busy_low", 64'(busy), 64'd0);
    check("tmo_no_quote", 64'(quote_valid), 64'd0);
    step();
    check("tmo_pulse_end", 64'(err_timeout), 64'd0);
    check("tmo_reissue_busy", 64'(busy), 64'd1);
    step();
    check("tmo_reissue_req", 64'(req_valid), 64'd1);
    check("tmo_reissue_vol", 64'(req_vol), 64'h33);
    step();
    resp_valid = 1'b1; resp_spread = 32'h5555;
    step();
    resp_valid = 1'b0;
    check("tmo_quote_valid", 64'(quote_valid), 64'd1);
    check("tmo_quote_sym", 64'(quote_symbol), 64'd3);
    check("tmo_quote_spr", 64'(quote_spread), 64'h5555);
    check("tmo_quote_err", 64'(err_timeout), 64'd0);
`ifdef SPREAD_SCHED_STATS_EN
    check("tmo_stat_issued", 64'(stat_issued), 64'd2);
    check("tmo_stat_timeouts", 64'(stat_timeouts), 64'd1);
`endif

    // Response on the final WAIT cycle counts as a response.
    do_reset();
    vol_valid = 1'b1; vol_symbol = 2'd1; volatility = 32'h77;
    step();
    vol_valid = 1'b0;
    step(); step();
    for (int k = 0; k < 15; k++) step();
    resp_valid = 1'b1; resp_spread = 32'hABCD;
    step();
    resp_valid = 1'b0;
    check("edge_quote_valid", 64'(quote_valid), 64'd1);
    check("edge_quote_sym", 64'(quote_symbol), 64'd1);
    check("edge_quote_spr", 64'(quote_spread), 64'hABCD);
    check("edge_err", 64'(err_timeout), 64'd0);
    step();
    check("edge_err_after", 64'(err_timeout), 64'd0);
    check("edge_no_reissue", 64'(busy), 64'd0);

    // Update sym1 in the same cycle it is granted: old value first, new value next.
    do_reset();
    exp_q.push_back(32'h10); exp_sym_q.push_back(2'd1);
    exp_q.push_back(32'h20); exp_sym_q.push_back(2'd1);
    vol_valid = 1'b1; vol_symbol = 2'd1; volatility = 32'h10;
    step();
    volatility = 32'h20;
    step();
    vol_valid = 1'b0;
    run_traffic("same", 20);

    // Reset while WAITing, then a late response: nothing comes out.
    do_reset();
    vol_valid = 1'b1; vol_symbol = 2'd0; volatility = 32'h55;
    step();
    vol_valid = 1'b0;
    step(); step();
    check("rst_req_sent", 64'(req_valid), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    resp_valid = 1'b1; resp_spread = 32'hDEAD;
    check_all_zero("rst_in_reset");
    step();
    resp_valid = 1'b0;
    check_all_zero("rst_late_resp");
    step();
    check("rst_no_quote_later", 64'(quote_valid), 64'd0);

    // Refresh wrap with period 8: seen = {0,2}; window between wraps holds 0 then 2.
    b_reset = 1'b1;
    step(); step();
    b_reset = 1'b0;
    b_vol_valid = 1'b1; b_vol_symbol = 2'd0; b_volatility = 32'hA0;
    step();
    b_vol_symbol = 2'd2; b_volatility = 32'hA2;
    step();
    b_vol_valid = 1'b0;
    pre_win = 0; other = 0; bquotes = 0; b_err_seen = 1'b0;
    for (int c = 2; c < 16; c++) begin
      @(negedge clk);
      b_resp_valid  = b_req_valid;
      b_resp_spread = b_req_vol;
      if (b_err) b_err_seen = 1'b1;
      if (b_quote_valid) begin
        bquotes++;
        bq_sym_q.push_back(b_quote_symbol);
      end
      if (b_req_valid) begin
        if (b_req_vol != 32'hA0 && b_req_vol != 32'hA2) other++;
        if (c >= 8) win_q.push_back(b_req_vol);
        else pre_win++;
      end
    end
    b_resp_valid = 1'b0;
    check("ref_initial_reqs", 64'(pre_win), 64'd2);
    check("ref_window_count", 64'(win_q.size()), 64'd2);
    if (win_q.size() == 2) begin
      check("ref_window_first", 64'(win_q[0]), 64'hA0);
      check("ref_window_second", 64'(win_q[1]), 64'hA2);
    end
    check("ref_unseen_reqs", 64'(other), 64'd0);
    check("ref_quote_count", 64'(bquotes), 64'd4);
    if (bq_sym_q.size() == 4) begin
      check("ref_quote_sym0", 64'(bq_sym_q[0]), 64'd0);
      check("ref_quote_sym1", 64'(bq_sym_q[1]), 64'd2);
      check("ref_quote_sym2", 64'(bq_sym_q[2]), 64'd0);
      check("ref_quote_sym3", 64'(bq_sym_q[3]), 64'd2);
    end
    check("ref_no_timeout", 64'(b_err_seen), 64'd0);
    check("ref_idle_after", 64'(b_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spread_scheduler.md
Name: spread_scheduler

Overview:
- Shares one spread datapath between NUM_SYMBOLS instrument channels.
- Latches per-symbol volatility updates and marks symbols pending. A round-robin arbiter picks one pending symbol at a time, issues it with the current time to the spread unit, and tags the returned spread with its symbol.
- Forces a periodic recompute so spreads track the shrinking time-to-terminal.
- Sits between the volatility estimators and the quote generator.

Parameters:
- DATA_WIDTH, 32, width of volatility, time and spread words.
- NUM_SYMBOLS, 4, number of requesting channels (>=2).
- SYM_W, $clog2(NUM_SYMBOLS), symbol index width.
- REFRESH_PERIOD, 1024, cycles between forced recompute of all valid symbols.
- RESP_TIMEOUT, 16, cycles allowed in WAIT before a request is abandoned.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_vol_valid  in  1  volatility update strobe.
- i_vol_symbol  in  SYM_W  symbol of the update.
- i_volatility  in  DATA_WIDTH  new volatility.
- i_curr_time  in  DATA_WIDTH  free-running time.
- o_req_valid  out  1  one-cycle request to the spread unit's data-valid input.
- o_req_volatility  out  DATA_WIDTH  volatility of the granted symbol.
- o_req_time  out  DATA_WIDTH  time captured at issue.
- i_resp_valid  in  1  spread unit result valid.
- i_resp_spread  in  DATA_WIDTH  spread result, fixed-point word.
- o_quote_valid  out  1  tagged result strobe.
- o_quote_symbol  out  SYM_W  symbol of the result.
- o_quote_spread  out  DATA_WIDTH  spread of the result.
- o_busy  out  1  high while in ISSUE or WAIT.
- o_err_timeout  out  1  one-cycle pulse on abandoned request.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; pending, seen and vol regs cleared; refresh counter 0; RR pointer 0. Reset mid-WAIT discards the in-flight request. A late i_resp_valid after reset is ignored.
- Update: on i_vol_valid, vol[sym] <= i_volatility, seen[sym] <= 1, pending[sym] <= 1. Last write wins.
- Refresh: counter counts 0..REFRESH_PERIOD-1 and wraps. On wrap, pending |= seen. Unseen symbols are never issued.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when any pending bit is set. The arbiter grants the first pending index strictly after the last grant (wraps). Latch gnt, vol[gnt] and i_curr_time. Clear pending[gnt].
  - ISSUE: o_req_valid=1 for exactly one cycle, then go to WAIT with the timeout counter at 0.
  - WAIT -> IDLE on i_resp_valid. Next cycle: o_quote_valid=1, o_quote_symbol=gnt, o_quote_spread=i_resp_spread.
  - WAIT -> IDLE when the counter reaches RESP_TIMEOUT-1 without a response. Pulse o_err_timeout and set pending[gnt] again.
- Update and grant on the same symbol in the same cycle: the request uses the old value, and pending stays 1 so the new value is issued later.
- Update and refresh in the same cycle: both set pending; there is no conflict.
- i_resp_valid outside WAIT is ignored. i_resp_valid on the timeout cycle counts as a response, with no error.
- Only one request is outstanding at a time.
- Minimum latency: update sampled at edge t, o_req_valid in cycle t+2, quote in cycle t+4 with a 1-cycle spread unit.
- Outputs hold their values between strobes; only the strobes are pulses.

Optional Feature:
- Macro: SPREAD_SCHED_STATS_EN.
- Defined: adds outputs o_stat_issued and o_stat_timeouts, both 16 bit. They increment on o_req_valid and on o_err_timeout, saturate at 0xFFFF, and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- spread_pkg holds:
  - the sched_state_e enum (IDLE, ISSUE, WAIT);
  - the quote_t struct (symbol, spread);
  - the default constants for REFRESH_PERIOD and RESP_TIMEOUT.
- Sub-module rr_arbiter: parameterised N. Inputs are the req vector, last-grant pointer and enable. Outputs are grant index and grant valid. It is combinational, and the pointer register stays in the scheduler.

Test Plan:
- Reset, then update sym2 vol=0x64 at t=5 -> o_req_valid in cycle 7 with vol 0x64. Respond in cycle 8 with 0x1234 -> o_quote_valid in cycle 9, symbol 2, spread 0x1234.
- Updates to sym0, sym1 and sym3 in the same window, with grant pointer last=0 -> issue order 1, 3, 0, with one request outstanding at a time.
- Withhold the response -> o_err_timeout pulses 16 cycles after WAIT entry. The symbol is re-issued, then a response arrives -> quote is produced.
- Seen = {0, 2} and counter wrap at REFRESH_PERIOD=8 (override) -> exactly two requests, for 0 then 2, and none for 1 or 3.
- Update sym1 in the same cycle sym1 is granted (old 0x10, new 0x20) -> first request carries 0x10, second carries 0x20.
- Assert i_reset during WAIT, then i_resp_valid next cycle -> no quote, all outputs 0. With SPREAD_SCHED_STATS_EN defined, counters read 0.
